// File: rtl/mc_pkg.sv
// Shared encodings for the multicycle MIPS control unit: states, opcodes,
// functs, ALU controls and the datapath mux selects.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH,
        DECODE,
        MEMADR,
        MEMRD,
        MEMWB,
        MEMWR,
        EXECUTE,
        ALUWB,
        ADDIEX,
        ADDIWB,
        BRANCH,
        JUMP
    } state_t;

    localparam logic [5:0] RTYPE = 6'b000000;
    localparam logic [5:0] LW    = 6'b100011;
    localparam logic [5:0] SW    = 6'b101011;
    localparam logic [5:0] BEQ   = 6'b000100;
    localparam logic [5:0] BNE   = 6'b000101;
    localparam logic [5:0] ADDI  = 6'b001000;
    localparam logic [5:0] J     = 6'b000010;

    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_SLT = 6'b101010;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    function automatic logic is_known_funct(input logic [5:0] f);
        return f inside {F_ADD, F_SUB, F_AND, F_OR, F_SLT};
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// Combinational ALU decode: aluop selects add/sub directly or defers to funct.
module mc_aludec
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            default: begin
                case (funct)
                    F_ADD:   alucontrol = ALU_ADD;
                    F_SUB:   alucontrol = ALU_SUB;
                    F_AND:   alucontrol = ALU_AND;
                    F_OR:    alucontrol = ALU_OR;
                    F_SLT:   alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing
// with mem_ready stalls in the memory access states.
module mc_controller
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       iord,
    output logic       memwrite,
    output logic       irwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic [2:0] alucontrol,
    output logic       pcen,
    output logic       illegal_op
);

    state_t     state, next_state;
    logic [1:0] aluop;
    logic       decode_legal;
    logic       memwrite_raw, irwrite_raw, regwrite_raw, pcen_raw;

    always_comb begin
        case (op)
            LW, SW, ADDI, BEQ, BNE, J: decode_legal = 1'b1;
            RTYPE:                     decode_legal = is_known_funct(funct);
            default:                   decode_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= FETCH;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            FETCH:   next_state = mem_ready ? DECODE : FETCH;
            DECODE: begin
                next_state = FETCH;
                if (decode_legal) begin
                    case (op)
                        LW, SW:   next_state = MEMADR;
                        RTYPE:    next_state = EXECUTE;
                        ADDI:     next_state = ADDIEX;
                        BEQ, BNE: next_state = BRANCH;
                        J:        next_state = JUMP;
                        default:  next_state = FETCH;
                    endcase
                end
            end
            MEMADR:  next_state = (op == LW) ? MEMRD : MEMWR;
            MEMRD:   next_state = mem_ready ? MEMWB : MEMRD;
            MEMWB:   next_state = FETCH;
            MEMWR:   next_state = mem_ready ? FETCH : MEMWR;
            EXECUTE: next_state = ALUWB;
            ALUWB:   next_state = FETCH;
            ADDIEX:  next_state = ADDIWB;
            ADDIWB:  next_state = FETCH;
            BRANCH:  next_state = FETCH;
            JUMP:    next_state = FETCH;
            default: next_state = FETCH;
        endcase
    end

    always_comb begin
        iord         = 1'b0;
        memwrite_raw = 1'b0;
        irwrite_raw  = 1'b0;
        regdst       = 1'b0;
        memtoreg     = 1'b0;
        regwrite_raw = 1'b0;
        alusrca      = 1'b0;
        alusrcb      = SRCB_B;
        pcsrc        = PC_ALU;
        aluop        = ALUOP_ADD;
        pcen_raw     = 1'b0;
        case (state)
            FETCH: begin
                alusrcb     = SRCB_FOUR;
                irwrite_raw = mem_ready;
                pcen_raw    = mem_ready;
            end
            DECODE:  alusrcb = SRCB_IMMSH;
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            MEMRD:   iord = 1'b1;
            MEMWB: begin
                memtoreg     = 1'b1;
                regwrite_raw = 1'b1;
            end
            MEMWR: begin
                iord         = 1'b1;
                memwrite_raw = 1'b1;
            end
            EXECUTE: begin
                alusrca = 1'b1;
                aluop   = ALUOP_FUNCT;
            end
            ALUWB: begin
                regdst       = 1'b1;
                regwrite_raw = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = SRCB_IMM;
            end
            ADDIWB:  regwrite_raw = 1'b1;
            BRANCH: begin
                alusrca  = 1'b1;
                aluop    = ALUOP_SUB;
                pcsrc    = PC_ALUOUT;
                // op[0] distinguishes bne from beq, flipping the taken sense
                pcen_raw = zero ^ op[0];
            end
            JUMP: begin
                pcsrc    = PC_JUMP;
                pcen_raw = 1'b1;
            end
            default: ;
        endcase
    end

    // Write strobes are gated by reset so an in-flight store drops immediately.
    assign memwrite   = memwrite_raw & ~reset;
    assign irwrite    = irwrite_raw  & ~reset;
    assign regwrite   = regwrite_raw & ~reset;
    assign pcen       = pcen_raw     & ~reset;
    assign illegal_op = (state == DECODE) & ~decode_legal & ~reset;

    mc_aludec u_aludec (
        .aluop      (aluop),
        .funct      (funct),
        .alucontrol (alucontrol)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: per-cycle output vectors checked against
// hand-built expectations, plus a count of accepted memory writes.
module tb_mc_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op, funct;
    logic       zero, mem_ready;
    logic       iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca;
    logic [1:0] alusrcb, pcsrc;
    logic [2:0] alucontrol;
    logic       pcen, illegal_op;

    int total = 0;
    int bad   = 0;
    int writes = 0;

    always #5 clk = ~clk;

    mc_controller dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .iord       (iord),
        .memwrite   (memwrite),
        .irwrite    (irwrite),
        .regdst     (regdst),
        .memtoreg   (memtoreg),
        .regwrite   (regwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .pcsrc      (pcsrc),
        .alucontrol (alucontrol),
        .pcen       (pcen),
        .illegal_op (illegal_op)
    );

    always @(posedge clk) begin
        if (memwrite && mem_ready)
            writes <= writes + 1;
    end

    // Bit order: iord memwrite irwrite regdst memtoreg regwrite alusrca
    //            alusrcb[1:0] pcsrc[1:0] alucontrol[2:0] pcen illegal_op
    function automatic logic [15:0] mk(input logic io, mw, ir, rd, mt, rw, asa,
                                       input logic [1:0] sb, pc,
                                       input logic [2:0] alu,
                                       input logic pe, il);
        return {io, mw, ir, rd, mt, rw, asa, sb, pc, alu, pe, il};
    endfunction

    localparam logic [15:0] V_FETCH   = 16'b0010_0000_1000_1010; // mem_ready=1
    localparam logic [15:0] V_FSTALL  = 16'b0000_0000_1000_1000; // mem_ready=0, also reset view
    localparam logic [15:0] V_DECODE  = 16'b0000_0001_1000_1000;
    localparam logic [15:0] V_DECILL  = 16'b0000_0001_1000_1001;
    localparam logic [15:0] V_MEMADR  = 16'b0000_0011_0000_1000;
    localparam logic [15:0] V_MEMRD   = 16'b1000_0000_0000_1000;
    localparam logic [15:0] V_MEMWB   = 16'b0000_1100_0000_1000;
    localparam logic [15:0] V_MEMWR   = 16'b1100_0000_0000_1000;
    localparam logic [15:0] V_ALUWB   = 16'b0001_0100_0000_1000;
    localparam logic [15:0] V_ADDIEX  = 16'b0000_0011_0000_1000;
    localparam logic [15:0] V_ADDIWB  = 16'b0000_0100_0000_1000;
    localparam logic [15:0] V_JUMP    = 16'b0000_0000_0100_1010;

    function automatic logic [15:0] v_branch(input logic taken);
        return mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, taken, 0);
    endfunction

    function automatic logic [15:0] v_exec(input logic [2:0] alu);
        return mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, alu, 0, 0);
    endfunction

    task automatic chk(input string tag, input logic [15:0] exp);
        logic [15:0] obs;
        obs = {iord, memwrite, irwrite, regdst, memtoreg, regwrite, alusrca,
               alusrcb, pcsrc, alucontrol, pcen, illegal_op};
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Inputs are set at a falling edge; sample 1ns later, then advance one cycle.
    task automatic step(input string tag, input logic [15:0] exp);
        #1;
        chk(tag, exp);
        @(negedge clk);
    endtask

    logic [5:0] fn_tab [5];
    logic [2:0] alu_tab [5];

    initial begin
        fn_tab  = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        alu_tab = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};

        reset = 1'b1; op = 6'b100011; funct = '0; zero = 1'b0; mem_ready = 1'b1;
        #2;
        chk("reset_outputs", V_FSTALL);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // lw: 5 cycles
        step("lw_fetch", V_FETCH);
        step("lw_decode", V_DECODE);
        step("lw_memadr", V_MEMADR);
        step("lw_memrd", V_MEMRD);
        step("lw_memwb", V_MEMWB);

        // bne, zero=0 -> taken
        op = 6'b000101;
        step("bne_fetch", V_FETCH);
        step("bne_decode", V_DECODE);
        zero = 1'b0;
        step("bne_z0_branch", v_branch(1'b1));
        // bne, zero=1 -> not taken
        step("bne2_fetch", V_FETCH);
        step("bne2_decode", V_DECODE);
        zero = 1'b1;
        step("bne_z1_branch", v_branch(1'b0));
        // beq polarity inverted
        op = 6'b000100;
        step("beq_fetch", V_FETCH);
        step("beq_decode", V_DECODE);
        zero = 1'b1;
        step("beq_z1_branch", v_branch(1'b1));
        step("beq2_fetch", V_FETCH);
        step("beq2_decode", V_DECODE);
        zero = 1'b0;
        step("beq_z0_branch", v_branch(1'b0));

        // sw with 3 stall cycles in MEMWR; mem_ready low in DECODE/MEMADR is ignored
        op = 6'b101011;
        writes = 0;
        step("sw_fetch", V_FETCH);
        mem_ready = 1'b0;
        step("sw_decode_ready_ignored", V_DECODE);
        step("sw_memadr_ready_ignored", V_MEMADR);
        step("sw_memwr_stall1", V_MEMWR);
        step("sw_memwr_stall2", V_MEMWR);
        step("sw_memwr_stall3", V_MEMWR);
        mem_ready = 1'b1;
        step("sw_memwr_accept", V_MEMWR);
        chk_int("sw_write_count", writes, 1);

        // FETCH stalled 2 cycles, then j
        op = 6'b000010;
        mem_ready = 1'b0;
        step("fetch_stall1", V_FSTALL);
        step("fetch_stall2", V_FSTALL);
        mem_ready = 1'b1;
        step("fetch_release", V_FETCH);
        step("j_decode", V_DECODE);
        step("j_jump", V_JUMP);

        // R-type over every supported funct
        op = 6'b000000;
        for (int i = 0; i < 5; i++) begin
            funct = fn_tab[i];
            step("r_fetch", V_FETCH);
            step("r_decode", V_DECODE);
            step("r_execute", v_exec(alu_tab[i]));
            step("r_aluwb", V_ALUWB);
        end

        // addi
        op = 6'b001000;
        step("addi_fetch", V_FETCH);
        step("addi_decode", V_DECODE);
        step("addi_ex", V_ADDIEX);
        step("addi_wb", V_ADDIWB);

        // illegal opcode and illegal funct
        writes = 0;
        op = 6'b111111;
        step("ill_op_fetch", V_FETCH);
        step("ill_op_decode", V_DECILL);
        op = 6'b000000; funct = 6'b000000;
        step("ill_fn_fetch", V_FETCH);
        step("ill_fn_decode", V_DECILL);
        op = 6'b000010;
        step("after_ill_fetch", V_FETCH);
        step("after_ill_decode", V_DECODE);
        step("after_ill_jump", V_JUMP);
        chk_int("ill_no_writes", writes, 0);

        // reset in the middle of MEMWR
        op = 6'b101011;
        step("swr_fetch", V_FETCH);
        step("swr_decode", V_DECODE);
        mem_ready = 1'b0;
        step("swr_memadr", V_MEMADR);
        #1;
        chk("swr_memwr_before_reset", V_MEMWR);
        #2;
        reset = 1'b1;
        #1;
        chk("swr_reset_drops_memwrite", V_FSTALL);
        mem_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("swr_held_in_reset", V_FSTALL);
        reset = 1'b0;
        op = 6'b001000;
        step("restart_fetch", V_FETCH);
        step("restart_decode", V_DECODE);
        step("restart_addiex", V_ADDIEX);
        step("restart_addiwb", V_ADDIWB);
        step("restart_back_fetch", V_FETCH);
        chk_int("swr_no_write", writes, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
